// File: rtl/flash_word_reader.sv
// flash_word_reader: 16-bit word reads from an 8-bit NOR flash over a toggle req/ack handshake, plus flash reset sequencing. Rev 1.0
// Build option: define FLASH_BYTESWAP_EN to place the even-address byte in ofl_data[7:0] instead of [15:8].
`default_nettype none

module flash_word_reader #(
  parameter int ACCESS_CYCLES = 5,
  parameter int RST_CYCLES    = 32,
  parameter int RST_RECOVERY  = 16
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic [22:0] ifl_addr,
  input  logic        ifl_req,
  output logic        ofl_ack,
  output logic [15:0] ofl_data,
  output logic        oready,
  output logic [22:0] ofl_a,
  input  logic [7:0]  ifl_dq,
  output logic        ofl_ce_n,
  output logic        ofl_oe_n,
  output logic        ofl_we_n,
  output logic        ofl_rst_n,
  output logic        ofl_wp_n
);

  localparam int c_RST_MAX = (RST_CYCLES > RST_RECOVERY) ? RST_CYCLES : RST_RECOVERY;
  localparam int c_RCW     = $clog2(c_RST_MAX + 1);

  localparam logic [3:0]       c_ACC_LAST = 4'(ACCESS_CYCLES - 1);
  localparam logic [c_RCW-1:0] c_RST_LAST = c_RCW'(RST_CYCLES - 1);
  localparam logic [c_RCW-1:0] c_REC_LAST = c_RCW'(RST_RECOVERY - 1);

`ifdef FLASH_BYTESWAP_EN
  localparam bit c_SWAP = 1'b1;
`else
  localparam bit c_SWAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    RST_ASSERT = 3'd0,
    RST_WAIT   = 3'd1,
    IDLE       = 3'd2,
    BYTE0      = 3'd3,
    BYTE1      = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t           r_state;
  logic [c_RCW-1:0] r_rst_cnt;
  logic [3:0]       r_acc_cnt;
  logic [22:1]      r_addr_q;
  logic [22:0]      r_a;
  logic [15:0]      r_data;
  logic             r_ack;
  logic             r_ready;
  logic             r_ce_n;
  logic             r_oe_n;
  logic             r_fl_rst_n;

  // Word alignment drops the byte-select bit of the request address.
  logic w_unused_addr0;
  assign w_unused_addr0 = ifl_addr[0];

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state    <= RST_ASSERT;
      r_rst_cnt  <= '0;
      r_acc_cnt  <= '0;
      r_addr_q   <= '0;
      r_a        <= '0;
      r_data     <= '0;
      r_ack      <= 1'b0;
      r_ready    <= 1'b0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_fl_rst_n <= 1'b0;
    end else begin
      case (r_state)
        RST_ASSERT: begin
          if (r_rst_cnt == c_RST_LAST) begin
            r_rst_cnt  <= '0;
            r_fl_rst_n <= 1'b1;
            r_state    <= RST_WAIT;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end

        RST_WAIT: begin
          if (r_rst_cnt == c_REC_LAST) begin
            r_rst_cnt <= '0;
            r_ready   <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end

        IDLE: begin
          r_ce_n <= 1'b1;
          r_oe_n <= 1'b1;
          if (ifl_req != r_ack) begin
            r_addr_q  <= ifl_addr[22:1];
            r_a       <= {ifl_addr[22:1], 1'b0};
            r_ce_n    <= 1'b0;
            r_oe_n    <= 1'b0;
            r_acc_cnt <= '0;
            r_state   <= BYTE0;
          end
        end

        BYTE0: begin
          if (r_acc_cnt == c_ACC_LAST) begin
            if (c_SWAP) r_data[7:0]  <= ifl_dq;
            else        r_data[15:8] <= ifl_dq;
            r_a       <= {r_addr_q, 1'b1};
            r_acc_cnt <= '0;
            r_state   <= BYTE1;
          end else begin
            r_acc_cnt <= r_acc_cnt + 1'b1;
          end
        end

        BYTE1: begin
          if (r_acc_cnt == c_ACC_LAST) begin
            if (c_SWAP) r_data[15:8] <= ifl_dq;
            else        r_data[7:0]  <= ifl_dq;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_acc_cnt <= r_acc_cnt + 1'b1;
          end
        end

        // Copying the live request absorbs any extra toggle seen mid-read.
        DONE: begin
          r_ack   <= ifl_req;
          r_state <= IDLE;
        end

        default: r_state <= RST_ASSERT;
      endcase
    end
  end

  assign ofl_ack   = r_ack;
  assign ofl_data  = r_data;
  assign oready    = r_ready;
  assign ofl_a     = r_a;
  assign ofl_ce_n  = r_ce_n;
  assign ofl_oe_n  = r_oe_n;
  assign ofl_rst_n = r_fl_rst_n;
  assign ofl_we_n  = 1'b1;
  assign ofl_wp_n  = 1'b0;

endmodule

`default_nettype wire
